aes256_key_sched_ctrl: RTL

- Sequencer that drives the shared AES-256 key-expansion datapath (type A step = RotWord/SubWord/rcon on the upper half; type B step = SubWord on the lower half) through the full 13-step schedule.
- Accepts a 256-bit cipher key with a start strobe and streams round keys rk0..rk14 (128 bits each) to the cipher round engine, one valid strobe per key.
- Sits between key load logic and the expansion datapath; owns the state register, rcon generation and A/B alternation.

---
 rtl/aes256_key_sched_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/aes256_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes256_key_sched_ctrl
//
// Sequencer for a shared AES-256 key-expansion datapath. A 256-bit cipher key
// is accepted with a start strobe. The block then streams the fifteen 128-bit
// round keys rk0..rk14 to the cipher round engine. rk0 and rk1 come straight
// from the key. rk2..rk14 come from 13 expansion steps that alternate between
// type A (RotWord/SubWord/rcon on the upper half) and type B (SubWord on the
// lower half), starting with A.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   key_in    cipher key, sampled only in the cycle start is accepted
//   start     begin a schedule; ignored while busy
//   busy      high from the cycle after acceptance through the rk14 cycle
//   done      one-cycle pulse, coincident with the rk14 strobe
//   rk_valid  one-cycle strobe per round key
//   rk_idx    index of rk_data (0..14), held between strobes
//   rk_data   round key, held between strobes
//   exp_in    expansion datapath input state
//   exp_rcon  round constant for type A steps, 0x00 for type B steps
//   exp_type  1 = type A step, 0 = type B step
//   exp_out   expansion datapath result, valid EXP_LAT cycles after exp_*
//
// Parameter
//   EXP_LAT   datapath latency in cycles (legal range 1..7)
// ---------------------------------------------------------------------------
module aes256_key_sched_ctrl #(
  parameter int unsigned EXP_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic [255:0] exp_in,
  output logic [7:0]   exp_rcon,
  output logic         exp_type,
  input  logic [255:0] exp_out
);

  localparam logic [2:0] LatLast  = 3'(EXP_LAT - 1);
  localparam logic [3:0] LastStep = 4'd13;

  typedef enum logic [2:0] {
    StIdle,
    StEmit0,
    StEmit1,
    StDrive,
    StCapture
  } state_e;

  state_e         r_fsm,      w_fsm_nxt;
  logic [255:0]   r_key,      w_key_nxt;      // running expansion state
  logic [3:0]     r_step,     w_step_nxt;     // expansion step 1..13
  logic [7:0]     r_rcon,     w_rcon_nxt;
  logic [2:0]     r_lat,      w_lat_nxt;      // cycles spent in DRIVE
  logic           r_done,     w_done_nxt;
  logic           r_rk_valid, w_rk_valid_nxt;
  logic [3:0]     r_rk_idx,   w_rk_idx_nxt;
  logic [127:0]   r_rk_data,  w_rk_data_nxt;

  logic           w_type_a;
  logic [7:0]     w_rcon_xt;

  // Odd steps are type A.
  assign w_type_a  = r_step[0];
  assign w_rcon_xt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= StIdle;
      r_key      <= '0;
      r_step     <= 4'd0;
      r_rcon     <= 8'h01;
      r_lat      <= 3'd0;
      r_done     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_idx   <= 4'd0;
      r_rk_data  <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_key      <= w_key_nxt;
      r_step     <= w_step_nxt;
      r_rcon     <= w_rcon_nxt;
      r_lat      <= w_lat_nxt;
      r_done     <= w_done_nxt;
      r_rk_valid <= w_rk_valid_nxt;
      r_rk_idx   <= w_rk_idx_nxt;
      r_rk_data  <= w_rk_data_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_key_nxt      = r_key;
    w_step_nxt     = r_step;
    w_rcon_nxt     = r_rcon;
    w_lat_nxt      = r_lat;
    w_done_nxt     = 1'b0;
    w_rk_valid_nxt = 1'b0;
    w_rk_idx_nxt   = r_rk_idx;
    w_rk_data_nxt  = r_rk_data;

    unique case (r_fsm)
      StIdle: begin
        // r_done marks the rk14 cycle, which still counts as busy.
        if (start && !r_done) begin
          w_fsm_nxt      = StEmit0;
          w_key_nxt      = key_in;
          w_step_nxt     = 4'd1;
          w_rcon_nxt     = 8'h01;
          // rk0 is registered here, so it is presented during EMIT0.
          w_rk_valid_nxt = 1'b1;
          w_rk_idx_nxt   = 4'd0;
          w_rk_data_nxt  = key_in[255:128];
        end
      end

      StEmit0: begin
        w_fsm_nxt      = StEmit1;
        w_rk_valid_nxt = 1'b1;
        w_rk_idx_nxt   = 4'd1;
        w_rk_data_nxt  = r_key[127:0];
      end

      StEmit1: begin
        w_fsm_nxt = StDrive;
        w_lat_nxt = 3'd0;
      end

      StDrive: begin
        if (r_lat == LatLast) begin
          w_fsm_nxt = StCapture;
        end else begin
          w_lat_nxt = r_lat + 3'd1;
        end
      end

      StCapture: begin
        w_key_nxt      = exp_out;
        w_rk_valid_nxt = 1'b1;
        w_rk_idx_nxt   = r_step + 4'd1;
        // Type A refreshes the upper half and type B the lower half.
        w_rk_data_nxt  = w_type_a ? exp_out[255:128] : exp_out[127:0];
        if (w_type_a) begin
          w_rcon_nxt = w_rcon_xt;
        end
        if (r_step == LastStep) begin
          w_fsm_nxt  = StIdle;
          w_done_nxt = 1'b1;
        end else begin
          w_fsm_nxt  = StDrive;
          w_step_nxt = r_step + 4'd1;
          w_lat_nxt  = 3'd0;
        end
      end

      default: w_fsm_nxt = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // exp_* must hold through DRIVE and CAPTURE. r_key only changes at the end
  // of CAPTURE, so driving them from state keeps them stable for the window.
  always_comb begin
    exp_in   = '0;
    exp_rcon = 8'h00;
    exp_type = 1'b0;
    if (r_fsm == StDrive || r_fsm == StCapture) begin
      exp_in   = r_key;
      exp_type = w_type_a;
      exp_rcon = w_type_a ? r_rcon : 8'h00;
    end
  end

  // The rk14 cycle is spent in IDLE with r_done set. It still counts as busy.
  assign busy     = (r_fsm != StIdle) || r_done;
  assign done     = r_done;
  assign rk_valid = r_rk_valid;
  assign rk_idx   = r_rk_idx;
  assign rk_data  = r_rk_data;

endmodule
